// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must be able to hold WIDTH.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;

  logic             cell_d;
  logic             cell_bout;
  logic [WIDTH:0]   res_ext;
  logic [WIDTH-1:0] res_shift;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
`endif

  full_subtractor u_cell (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .bin  (br_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  always_comb begin
    state_d   = state_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    res_d     = res_q;
    diff_d    = diff_q;
    cnt_d     = cnt_q;
    br_d      = br_q;
    bout_d    = bout_q;
    res_ext   = {cell_d, res_q};
    res_shift = res_ext[WIDTH:1];
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    a_msb_d   = a_msb_q;
    b_msb_d   = b_msb_q;
    ovf_d     = ovf_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          sa_d    = a;
          sb_d    = b;
          br_d    = bin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end
      end
      RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        br_d  = cell_bout;
        res_d = res_shift;
        cnt_d = cnt_q + 1'b1;
        // Final bit: publish the result straight from the cell output.
        if (cnt_q == LAST) begin
          state_d = DONE;
          diff_d  = res_shift;
          bout_d  = cell_bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          ovf_d   = (a_msb_q != b_msb_q) && (res_shift[WIDTH-1] != a_msb_q);
`endif
        end
      end
      DONE: begin
        if (done_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign start_ready = (state_q == IDLE);
  assign done_valid  = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign diff        = diff_q;
  assign bout        = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  assign ovf         = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed testbench for serial_subtractor (WIDTH=8); ovf checks only with SERIAL_SUBTRACTOR_OVF_EN.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic [W-1:0] diff;
  logic         bout;
  logic         done_valid;
  logic         done_ready = 1'b1;
  logic         busy;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic         ovf;
`endif

  int errors = 0;
  int checks = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .bin         (bin),
    .diff        (diff),
    .bout        (bout),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .busy        (busy)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .ovf         (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Accepts one operand set from IDLE and waits (bounded) for done_valid.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ibin, output int lat);
    a = ia; b = ib; bin = ibin; start_valid = 1'b1;
    tick;
    start_valid = 1'b0;
    lat = 0;
    while (!done_valid && lat < 100) begin
      tick;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({start_ready, done_valid, busy, bout, diff} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("[TB] FAIL reset_values: got rdy/vld/busy/bout/diff=%b%b%b%b/%h required 1000/00",
               start_ready, done_valid, busy, bout, diff);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    int lat;
    int busy_low;
    a = 8'h05; b = 8'h03; bin = 1'b0; start_valid = 1'b1;
    tick;
    start_valid = 1'b0;
    lat = 0;
    busy_low = 0;
    while (!done_valid && lat < 100) begin
      if (!busy) busy_low++;
      tick;
      lat++;
    end
    if (!busy) busy_low++;
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("[TB] FAIL basic_latency: got %0d cycles required 8", lat);
    end
    checks++;
    if (busy_low !== 0) begin
      errors++;
      $display("[TB] FAIL basic_busy: got %0d busy-low cycles required 0", busy_low);
    end
    checks++;
    if ({bout, diff} !== {1'b0, 8'h02}) begin
      errors++;
      $display("[TB] FAIL basic_result: got bout=%b diff=%h required bout=0 diff=02", bout, diff);
    end
    tick;
  endtask

  task automatic test_borrow;
    int lat;
    run_op(8'h00, 8'h01, 1'b0, lat);
    checks++;
    if ({bout, diff} !== {1'b1, 8'hFF}) begin
      errors++;
      $display("[TB] FAIL borrow_0_minus_1: got bout=%b diff=%h required bout=1 diff=ff", bout, diff);
    end
    tick;
    run_op(8'h10, 8'h10, 1'b1, lat);
    checks++;
    if ({bout, diff} !== {1'b1, 8'hFF}) begin
      errors++;
      $display("[TB] FAIL borrow_bin: got bout=%b diff=%h required bout=1 diff=ff", bout, diff);
    end
    tick;
  endtask

  task automatic test_backpressure;
    int lat;
    done_ready = 1'b0;
    run_op(8'h33, 8'h11, 1'b0, lat);
    a = 8'h01; b = 8'h02; bin = 1'b1; start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({done_valid, start_ready, bout, diff} !== {1'b1, 1'b0, 1'b0, 8'h22}) begin
        errors++;
        $display("[TB] FAIL hold_cycle%0d: got vld/rdy/bout/diff=%b%b%b/%h required 100/22",
                 i, done_valid, start_ready, bout, diff);
      end
      tick;
    end
    a = 8'h09; b = 8'h04; bin = 1'b1;
    done_ready = 1'b1;
    tick;
    checks++;
    if ({start_ready, done_valid, diff} !== {1'b1, 1'b0, 8'h22}) begin
      errors++;
      $display("[TB] FAIL release_idle: got rdy/vld/diff=%b%b/%h required 10/22",
               start_ready, done_valid, diff);
    end
    tick;
    start_valid = 1'b0;
    checks++;
    if ({busy, start_ready} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL next_accept: got busy/rdy=%b%b required 10", busy, start_ready);
    end
    lat = 0;
    while (!done_valid && lat < 100) begin
      tick;
      lat++;
    end
    checks++;
    if ({bout, diff} !== {1'b0, 8'h04}) begin
      errors++;
      $display("[TB] FAIL after_release: got bout=%b diff=%h required bout=0 diff=04", bout, diff);
    end
    tick;
  endtask

  task automatic test_reset_mid_run;
    int seen;
    a = 8'hC3; b = 8'h5A; bin = 1'b0; start_valid = 1'b1;
    tick;
    start_valid = 1'b0;
    tick; tick; tick;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({start_ready, done_valid, busy, bout, diff} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("[TB] FAIL async_reset: got rdy/vld/busy/bout/diff=%b%b%b%b/%h required 1000/00",
               start_ready, done_valid, busy, bout, diff);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (done_valid) seen++;
    end
    checks++;
    if ({seen != 0, start_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL post_reset: got done_valid count=%0d rdy=%b required 0 and 1", seen, start_ready);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [W-1:0] ra, rb;
    logic rbin;
    logic [W:0] exp;
    done_ready = 1'b1;
    for (int n = 0; n < 200; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rbin = 1'($urandom);
      exp = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
      run_op(ra, rb, rbin, lat);
      checks++;
      if ({bout, diff} !== exp || lat !== W) begin
        errors++;
        $display("[TB] FAIL sweep%0d %h-%h-%b: got bout=%b diff=%h lat=%0d required bout=%b diff=%h lat=%0d",
                 n, ra, rb, rbin, bout, diff, lat, exp[W], exp[W-1:0], W);
      end
      tick;
    end
  endtask

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  task automatic test_ovf;
    int lat;
    run_op(8'h80, 8'h01, 1'b0, lat);
    checks++;
    if ({ovf, bout, diff} !== {1'b1, 1'b0, 8'h7F}) begin
      errors++;
      $display("[TB] FAIL ovf_80_01: got ovf=%b bout=%b diff=%h required 1 0 7f", ovf, bout, diff);
    end
    tick;
    run_op(8'h7F, 8'hFF, 1'b0, lat);
    checks++;
    if ({ovf, bout, diff} !== {1'b1, 1'b1, 8'h80}) begin
      errors++;
      $display("[TB] FAIL ovf_7f_ff: got ovf=%b bout=%b diff=%h required 1 1 80", ovf, bout, diff);
    end
    tick;
    run_op(8'h05, 8'h03, 1'b0, lat);
    checks++;
    if ({ovf, bout, diff} !== {1'b0, 1'b0, 8'h02}) begin
      errors++;
      $display("[TB] FAIL ovf_05_03: got ovf=%b bout=%b diff=%h required 0 0 02", ovf, bout, diff);
    end
    tick;
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_borrow;
    test_backpressure;
    test_reset_mid_run;
    test_back_to_back;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    test_ovf;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor, the subtraction counterpart of the team's combinational full-adder cell.
- Accepts two operands and a borrow-in through a valid/ready handshake.
- Resolves one bit per clock, LSB first, using a single full-subtractor cell and a borrow flop.
- Presents the difference and borrow-out through an output valid/ready handshake.
- Used as an area-cheap arithmetic datapath element beside the existing adder blocks.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range is WIDTH >= 1.

Ports:
- clk, input, 1, single clock, rising-edge.
- rst_n, input, 1, asynchronous active-low reset.
- start_valid, input, 1, operands a/b/bin are valid.
- start_ready, output, 1, block can accept operands.
- a, input, WIDTH, minuend.
- b, input, WIDTH, subtrahend.
- bin, input, 1, borrow-in.
- diff, output, WIDTH, result (a - b - bin) mod 2^WIDTH.
- bout, output, 1, borrow-out.
- done_valid, output, 1, diff/bout are valid.
- done_ready, input, 1, consumer accepts the result.
- busy, output, 1, high in RUN or DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. All flops clear immediately on rst_n low.
- Reset values: state=IDLE, start_ready=1, done_valid=0, busy=0, diff=0, bout=0. Internal shift registers, borrow flop and counter are all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid && start_ready: latch a into sa and b into sb; borrow flop <= bin; result shift register <= 0; count <= 0; go to RUN.
- RUN, one iteration per cycle:
  - Cell computes d = sa[0]^sb[0]^br.
  - Cell computes br_next = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&br).
  - d shifts into the result MSB (result shifts right); sa and sb shift right; br <= br_next; count++.
  - When count reaches WIDTH-1 at the edge, go to DONE. diff is loaded from the final result and bout from br_next.
- Latency: done_valid is high exactly WIDTH cycles after the accepting edge. WIDTH=1 gives one cycle.
- DONE:
  - done_valid=1.
  - diff and bout are held stable until done_valid && done_ready.
  - After the accepting edge: go to IDLE, done_valid=0. diff/bout keep their last value.
- No overlap: start_ready=0 in RUN and DONE. start_valid in those states is ignored and operands are not sampled. Earliest next accept is the cycle after the result handshake.
- Arithmetic:
  - bout=1 iff unsigned a < b + bin.
  - Counter width is $clog2(WIDTH+1).
  - Inputs a/b/bin may change freely after acceptance without affecting the result.
- Reset mid-operation: aborts immediately and returns to reset values. No partial result is ever flagged valid.
- done_ready high in IDLE or RUN has no effect.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), signed two's-complement overflow.
  - ovf = (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]), using the latched operand MSBs captured at acceptance.
  - Valid with done_valid and held with diff; resets to 0.
  - bin does not affect the ovf formula.
- Undefined: port ovf and its MSB capture flops are absent. All other behaviour is identical.

Decomposition:
- Package serial_subtractor_pkg holds:
  - state enum typedef (IDLE, RUN, DONE);
  - a localparam function for counter width.
- Sub-module full_subtractor: combinational (a, b, bin) -> (d, bout). It is instantiated once in the datapath and is unit-testable in isolation against its 8-row truth table.

Test Plan (WIDTH=8):
1. a=0x05, b=0x03, bin=0, start_valid pulse -> diff=0x02, bout=0; done_valid rises 8 cycles after the accept; busy high throughout.
2. a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1. Then a=0x10, b=0x10, bin=1 -> diff=0xFF, bout=1.
3. Backpressure:
   - Hold done_ready=0 for 5 cycles after done_valid; drive start_valid=1 with new operands the whole time.
   - Required: diff/bout/done_valid stable, start_ready=0, new operands not taken.
   - Then done_ready=1: IDLE next cycle, next accept one cycle later.
4. Reset mid-RUN: assert rst_n=0 asynchronously 3 cycles after accept -> outputs go to reset values immediately without a clock edge. After release, start_ready=1 and no done_valid appears.
5. Back-to-back random sweep: 200 operand sets with done_ready always 1 -> each result matches (a-b-bin) mod 256 and borrow. Throughput is one result per WIDTH+2 cycles.
6. With SERIAL_SUBTRACTOR_OVF_EN:
   - a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1.
   - a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
   - a=0x05, b=0x03 -> ovf=0.
